bin2seg_scan: RTL and testbench
===============================

// Module: bin2seg_scan
// PURPOSE
//  Upstream feeder for the BCD-to-7-segment decoder. Accepts a binary value via
//  a load strobe, converts it to BCD with a sequential double-dabble engine,
//  then time-multiplexes the digits onto one shared decoder. Outputs the 5-bit
//  digit code (0-F; 5'h10 = blank) plus active-low one-hot digit enables.
// PARAMETERS
//  N_DIGITS     4      number of digits scanned (max value 10^N_DIGITS-1)
//  DATA_W       14     binary input width
//  REFRESH_DIV  50000  clock cycles each digit stays enabled (>=2)
//  BLANK_LZ     1      1 = blank leading zeros, 0 = show all digits
// PORTS
//  clk      in   1           system clock, all logic on rising edge
//  rst      in   1           synchronous reset, active-low
//  data_in  in   DATA_W      binary value to display
//  load     in   1           1-cycle strobe: capture data_in
//  busy     out  1           conversion in progress; load ignored while high
//  ovf      out  1           last accepted value exceeded 10^N_DIGITS-1
//  num      out  5           digit code to decoder: 0-F, or 5'h10 = blank
//  an       out  N_DIGITS    digit enables, active-low one-hot
// BEHAVIOUR
//  Reset (rst=0 at clk edge): busy=0, ovf=0, num=5'h10, an=all 1s, display
//   register=0, digit index=0, refresh counter=0, FSM->IDLE. Reset at any time
//   aborts a running conversion and clears the display.
//  Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
//   IDLE: on load=1, latch data_in, clear BCD shift reg, shift count=0, go
//    SHIFT; busy=1 from the next cycle.
//   SHIFT: one iteration per cycle: every BCD nibble >=5 gets +3, then shift
//    {bcd,bin} left by 1. Exactly DATA_W iterations, then go COMMIT.
//   COMMIT: one cycle; copy BCD to display register; ovf=1 if latched value >
//    10^N_DIGITS-1 (display register forced to all 4'hE), else ovf=0; go IDLE,
//    busy=0 next cycle. Load-to-busy-fall latency = DATA_W+2 cycles.
//   load while busy=1: ignored, no effect on conversion or display.
//  Display register changes only in COMMIT: scan never shows partial results.
//  Scanner (runs continuously, independent of FSM):
//   refresh counter 0..REFRESH_DIV-1; at terminal count wraps to 0 and digit
//    index advances; index N_DIGITS-1 wraps to 0.
//   an and num registered: an[idx]=0, others 1; num={1'b0,digit[idx]} or
//    5'h10 if blanked. First cycle after reset release drives idx 0.
//   Blanking (BLANK_LZ=1, ovf=0): digit i>0 blanked when digits i..N-1 all 0;
//    digit 0 never blanked (value 0 shows "0"). ovf=1 disables blanking.
//  Width rules: BCD reg is 4*N_DIGITS bits; the compare uses full-width
//   unsigned arithmetic, no truncation of data_in.
// TESTING (N_DIGITS=4, DATA_W=14, REFRESH_DIV=4)
//  load 1234 -> busy high 16 cycles; then num 4,3,2,1 with an 1110,1101,1011,
//   0111, 4 cycles each, repeating; ovf=0.
//  load 7 -> num 7,10h,10h,10h; load 0 -> num 0,10h,10h,10h; BLANK_LZ=0 with
//   load 7 -> num 7,0,0,0.
//  load 10000 -> ovf=1, num E,E,E,E on all digits; then load 42 -> ovf=0,
//   num 2,4,10h,10h.
//  load 1234, then load 9999 3 cycles later (busy) -> ignored; display 1234;
//   old value kept on display until COMMIT of the accepted load.
//  rst=0 mid-SHIFT -> next cycle busy=0, an=1111, num=10h; after release
//   display shows 0 (num 0,10h,10h,10h).
//  Scan wrap: run >=3 full scan periods; an always exactly one 0, index order
//   0->1->2->3->0, each digit enabled exactly REFRESH_DIV cycles.

Source files
------------

// File: rtl/bin2seg_scan.sv
// bin2seg_scan: binary-to-BCD converter (sequential double-dabble) feeding a
// time-multiplexed digit scanner for one shared 7-segment decoder.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active-low
//   data_in  binary value to display (DATA_W bits)
//   load     1-cycle strobe, captures data_in when not busy
//   busy     conversion in progress, load ignored while high
//   ovf      last accepted value exceeded 10^N_DIGITS-1
//   num      digit code to decoder: 0-F, or 5'h10 = blank
//   an       digit enables, active-low one-hot
module bin2seg_scan #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned DATA_W      = 14,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                load,
    output logic                busy,
    output logic                ovf,
    output logic [4:0]          num,
    output logic [N_DIGITS-1:0] an
);

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned SC_W  = $clog2(DATA_W + 1);
    localparam int unsigned RC_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CMP_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;

    // 10^N_DIGITS - 1; always fits in BCD_W bits since 10^N < 16^N
    function automatic logic [CMP_W-1:0] max_value();
        logic [CMP_W-1:0] p;
        p = CMP_W'(1);
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            p = p * CMP_W'(10);
        end
        return p - CMP_W'(1);
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = max_value();

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] bin;
    logic [BCD_W-1:0]  bcd;
    logic [BCD_W-1:0]  bcd_adj;
    logic [SC_W-1:0]   shift_cnt;
    logic              over;
    logic [3:0]        disp [N_DIGITS];
    logic [RC_W-1:0]   rcnt;
    logic [IDX_W-1:0]  idx;
    logic [N_DIGITS-1:0] blank;
    logic              upper_zero;

    // Converter state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Converter next-state; busy gates acceptance so the visible busy flag is authoritative
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load && !busy) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_cnt == SC_W'(DATA_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign over = CMP_W'(value) > MAX_VAL;

    // Converter datapath; busy stays high through the cycle after COMMIT
    always_ff @(posedge clk) begin
        if (!rst) begin
            value     <= '0;
            bin       <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                disp[i] <= 4'd0;
            end
        end else begin
            busy <= (state_q != IDLE) || (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        value     <= data_in;
                        bin       <= data_in;
                        bcd       <= '0;
                        shift_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    shift_cnt  <= shift_cnt + SC_W'(1);
                end
                COMMIT: begin
                    ovf <= over;
                    for (int i = 0; i < int'(N_DIGITS); i++) begin
                        disp[i] <= over ? 4'hE : bcd[4*i +: 4];
                    end
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking: digit i>0 blank when it and all higher digits are 0
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (disp[i] == 4'd0);
            blank[i]   = (i != 0) & upper_zero & (BLANK_LZ != 0) & ~ovf;
        end
    end

    // Scanner: free-running refresh counter, digit index and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt <= '0;
            idx  <= '0;
            an   <= '1;
            num  <= 5'h10;
        end else begin
            an  <= ~(N_DIGITS'(1) << idx);
            num <= blank[idx] ? 5'h10 : {1'b0, disp[idx]};
            if (rcnt == RC_W'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                rcnt <= rcnt + RC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bin2seg_scan.sv
// Self-checking bench for bin2seg_scan (N_DIGITS=4, DATA_W=14, REFRESH_DIV=4).
// Two instances share stimulus: one with leading-zero blanking, one without.
// A cycle-level reference model built from decimal arithmetic and a simple
// load-to-commit timer predicts busy/ovf/an/num every cycle.
module tb_bin2seg_scan;

    localparam int ND = 4;
    localparam int DW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          load = 1'b0;
    logic          busy, ovf, busy0, ovf0;
    logic [4:0]    num, num0;
    logic [ND-1:0] an, an0;

    bin2seg_scan #(.N_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .busy(busy), .ovf(ovf), .num(num), .an(an)
    );

    bin2seg_scan #(.N_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .BLANK_LZ(0)) u_dut_nlz (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load),
        .busy(busy0), .ovf(ovf0), .num(num0), .an(an0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int   p10 [ND] = '{1, 10, 100, 1000};
    bit   m_seen = 0;
    bit   m_busy = 0, m_ovf = 0, m_tail = 0;
    int   m_val = 0, m_lat = 0, m_cd = 0, m_cyc = 0;
    int   e_idx, d;
    logic [ND-1:0] e_an = '1;
    logic [4:0]    e_num = 5'h10, e_num0 = 5'h10;
    logic          e_busy = 0, e_ovf = 0;

    // Accepted load commits 15 edges later; busy drops one edge after that.
    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_ovf = 0; m_tail = 0; m_val = 0; m_cd = 0; m_cyc = 0;
            e_an = '1; e_num = 5'h10; e_num0 = 5'h10;
        end else begin
            e_idx = (m_cyc / RD) % ND;
            e_an = '1;
            e_an[e_idx] = 1'b0;
            if (m_ovf) begin
                e_num  = 5'h0E;
                e_num0 = 5'h0E;
            end else begin
                d = (m_val / p10[e_idx]) % 10;
                e_num0 = {1'b0, 4'(d)};
                e_num  = (e_idx > 0 && m_val < p10[e_idx]) ? 5'h10 : e_num0;
            end
            m_cyc++;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_tail = 1;
                    m_ovf  = (m_lat > 9999);
                    if (!m_ovf) m_val = m_lat;
                end
            end else if (m_tail) begin
                m_tail = 0;
                m_busy = 0;
            end else if (load && !m_busy) begin
                m_lat  = int'(data_in);
                m_cd   = 15;
                m_busy = 1;
            end
        end
        e_busy = m_busy;
        e_ovf  = m_ovf;
        m_seen = 1;
    end

    always @(negedge clk) begin
        if (m_seen) begin
            check("busy", 32'(busy), 32'(e_busy));
            check("ovf", 32'(ovf), 32'(e_ovf));
            check("an", 32'(an), 32'(e_an));
            check("num", 32'(num), 32'(e_num));
            check("busy_nlz", 32'(busy0), 32'(e_busy));
            check("ovf_nlz", 32'(ovf0), 32'(e_ovf));
            check("an_nlz", 32'(an0), 32'(e_an));
            check("num_nlz", 32'(num0), 32'(e_num0));
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        @(negedge clk);
        data_in = DW'(v);
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        data_in = DW'($urandom_range(0, 16383));
    endtask

    // Load and count cycles with busy high (bounded)
    task automatic load_measure(input int v, input string tag);
        int n;
        do_load(v);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'd16);
    endtask

    // Wait until a given digit is enabled and check its code
    task automatic expect_digit(input logic [ND-1:0] tgt_an, input logic [4:0] exp_num, input string tag);
        int n;
        n = 0;
        while (an !== tgt_an && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(num), 32'(exp_num));
    endtask

    initial begin
        int v, gap;
        rst = 1'b0;
        cycles(3);
        check("rst_an", 32'(an), 32'hF);
        check("rst_num", 32'(num), 32'h10);
        rst = 1'b1;

        load_measure(1234, "busy_len_1234");
        cycles(3 * RD * ND);
        expect_digit(4'b1110, 5'h4, "d0_1234");
        expect_digit(4'b0111, 5'h1, "d3_1234");

        load_measure(7, "busy_len_7");
        cycles(2 * RD * ND);
        expect_digit(4'b1101, 5'h10, "d1_7_blank");
        load_measure(0, "busy_len_0");
        cycles(2 * RD * ND);
        expect_digit(4'b1110, 5'h0, "d0_0");

        load_measure(10000, "busy_len_10000");
        cycles(2 * RD * ND);
        check("ovf_10000", 32'(ovf), 32'd1);
        load_measure(42, "busy_len_42");
        cycles(2 * RD * ND);
        check("ovf_42", 32'(ovf), 32'd0);

        // Load during busy is ignored
        do_load(1234);
        cycles(2);
        do_load(9999);
        cycles(30);
        expect_digit(4'b0111, 5'h1, "ignored_9999");

        // Reset mid-conversion
        do_load(5678);
        cycles(5);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_num", 32'(num), 32'h10);
        rst = 1'b1;
        cycles(2 * RD * ND);

        // Randomized loads with random gaps, some landing while busy
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 16383);
            endcase
            do_load(v);
            gap = $urandom_range(0, 40);
            cycles(gap);
        end
        cycles(3 * RD * ND);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
